// File: rtl/wb_to_axi_bridge_if.sv
// Bus bundles for wb_to_axi_bridge: a Wishbone classic (B3) port and an AXI4 port.
// Both interfaces live here so the bridge and its bench share one definition.

// Wishbone classic: cyc&stb raise a request; the slave answers with one ack or err cycle.
// adr is a word address; dat_wr flows master->slave, dat_rd flows slave->master.
interface wb_bus_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    localparam int WORD_ADDR_WIDTH = ADDR_WIDTH - $clog2(STRB_WIDTH);

    logic [WORD_ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0]      dat_wr;
    logic [DATA_WIDTH-1:0]      dat_rd;
    logic [STRB_WIDTH-1:0]      sel;
    logic                       we;
    logic                       cyc;
    logic                       stb;
    logic                       ack;
    logic                       err;

    modport master (
        output adr, dat_wr, sel, we, cyc, stb,
        input  dat_rd, ack, err
    );

    modport slave (
        input  adr, dat_wr, sel, we, cyc, stb,
        output dat_rd, ack, err
    );
endinterface

// AXI4 handshake: a beat transfers on a rising clk edge where valid and ready are both
// high; once valid rises it stays high with a stable payload until that edge.
interface axi_bus_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
);
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/wb_to_axi_bridge.sv
// Wishbone classic slave to AXI4 master: each Wishbone cycle becomes one single-beat AXI access.
// Define WB_AXI_ERR_EN to turn non-OKAY bresp/rresp into wb err instead of ack.
module wb_to_axi_bridge #(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_WIDTH = 32,
    parameter int                  STRB_WIDTH = DATA_WIDTH / 8,
    parameter int                  ID_WIDTH   = 8,
    parameter logic [ID_WIDTH-1:0] AXI_ID     = '0
) (
    input  logic       clk,
    input  logic       rst,
    wb_bus_if.slave    wb,
    axi_bus_if.master  m_axi,
    output logic [1:0] dbg_state
);
    localparam int LSB = $clog2(STRB_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        ACK  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  ack_q, ack_d;
    logic                  abort_q, abort_d;
    logic                  hold_q, hold_d;
    logic                  finish;
    logic                  deliver;
`ifdef WB_AXI_ERR_EN
    logic                  err_q, err_d;
    logic                  resp_bad;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        abort_d   = abort_q;
        hold_d    = hold_q;
        finish    = 1'b0;
`ifdef WB_AXI_ERR_EN
        resp_bad  = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                // hold_q masks the first IDLE after ACK, where stb may still be left high.
                hold_d = 1'b0;
                if (!hold_q && wb.cyc && wb.stb) begin
                    addr_d  = ADDR_WIDTH'(wb.adr) << LSB;
                    wdata_d = wb.dat_wr;
                    wstrb_d = wb.sel;
                    abort_d = 1'b0;
                    if (wb.we) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        bready_d  = 1'b1;
                        state_d   = WR;
                    end else begin
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                        state_d   = RD;
                    end
                end
            end

            WR: begin
                if (!wb.cyc) abort_d = 1'b1;
                if (awvalid_q && m_axi.awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi.wready) wvalid_d = 1'b0;
                // A B arriving before both AW and W have completed is ignored.
                if (bready_q && m_axi.bvalid && !awvalid_q && !wvalid_q) begin
                    bready_d = 1'b0;
                    finish   = 1'b1;
`ifdef WB_AXI_ERR_EN
                    resp_bad = (m_axi.bresp != 2'b00);
`endif
                    state_d  = ACK;
                end
            end

            RD: begin
                if (!wb.cyc) abort_d = 1'b1;
                if (arvalid_q && m_axi.arready) arvalid_d = 1'b0;
                if (rready_q && m_axi.rvalid) begin
                    rready_d  = 1'b0;
                    arvalid_d = 1'b0;
                    rdata_d   = m_axi.rdata;
                    finish    = 1'b1;
`ifdef WB_AXI_ERR_EN
                    resp_bad  = (m_axi.rresp != 2'b00);
`endif
                    state_d   = ACK;
                end
            end

            ACK: begin
                hold_d  = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        // An abandoned Wishbone cycle still finishes on AXI but gets no response pulse.
        deliver = finish && !abort_q && wb.cyc;
`ifdef WB_AXI_ERR_EN
        ack_d = deliver && !resp_bad;
        err_d = deliver && resp_bad;
`else
        ack_d = deliver;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ack_q     <= 1'b0;
            abort_q   <= 1'b0;
            hold_q    <= 1'b0;
`ifdef WB_AXI_ERR_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            ack_q     <= ack_d;
            abort_q   <= abort_d;
            hold_q    <= hold_d;
`ifdef WB_AXI_ERR_EN
            err_q     <= err_d;
`endif
        end
    end

    assign m_axi.awid    = AXI_ID;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awlen   = 8'd0;
    assign m_axi.awsize  = 3'(LSB);
    assign m_axi.awburst = 2'b01;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = 4'b0011;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid_q;

    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.wlast   = wvalid_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;

    assign m_axi.arid    = AXI_ID;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arlen   = 8'd0;
    assign m_axi.arsize  = 3'(LSB);
    assign m_axi.arburst = 2'b01;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = 4'b0011;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

    assign wb.dat_rd = rdata_q;
    assign wb.ack    = ack_q;
    assign dbg_state = state_q;

    // IDs and rlast carry nothing for single-beat, single-outstanding traffic.
`ifdef WB_AXI_ERR_EN
    assign wb.err = err_q;
    logic unused_axi;
    assign unused_axi = ^{m_axi.bid, m_axi.rid, m_axi.rlast};
`else
    assign wb.err = 1'b0;
    logic unused_axi;
    assign unused_axi = ^{m_axi.bid, m_axi.rid, m_axi.rlast, m_axi.bresp, m_axi.rresp};
`endif
endmodule
